// File: rtl/versatile_updown_counter_pkg.sv
// Shared constants and the direction decode for the versatile up/down counter.
// Direction is derived from the two count enables; conflicting or absent enables mean hold.
package versatile_updown_counter_pkg;

    localparam int DEFAULT_WIDTH        = 8;
    localparam int DEFAULT_PRESET_VALUE = 200;

    typedef enum logic [1:0] {
        DIR_HOLD = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DN   = 2'd2
    } dir_e;

    function automatic dir_e decode_dir(input logic up, input logic dn);
        dir_e dir;
        case ({up, dn})
            2'b10:   dir = DIR_UP;
            2'b01:   dir = DIR_DN;
            default: dir = DIR_HOLD;
        endcase
        return dir;
    endfunction

endpackage

// File: rtl/versatile_updown_counter_rise_edge_detect.sv
// Rising-edge detector: one-cycle pulse when din goes 0->1, so a held-high level fires once.
// The previous-sample register clears on reset, so a level high right after reset counts as an edge.
module rise_edge_detect
    import versatile_updown_counter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic din_q;

    // Previous-cycle sample of din.
    always_ff @(posedge clk) begin
        if (rst) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    assign pulse = din & ~din_q;

endmodule

// File: rtl/versatile_updown_counter.sv
// Presettable, pausable, saturating up/down counter with a sticky terminal-count flag.
// Priority below reset: preset load > pause > count > hold.
module versatile_updown_counter
    import versatile_updown_counter_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int PRESET_VALUE = DEFAULT_PRESET_VALUE
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             new_cntr_preset,
    input  logic [WIDTH-1:0] new_cntr_preset_value,
    input  logic             enable_cnt_up,
    input  logic             enable_cnt_dn,
    input  logic             pause_counting,
    output logic             ctr_expired
);

    localparam logic [WIDTH-1:0] MAX_CNT    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_CNT   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_CNT    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] PRESET_CNT = WIDTH'(PRESET_VALUE);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] cnt_dec;
    logic             expired_nxt;
    logic             load_pulse;
    dir_e             dir;

    rise_edge_detect u_preset_edge (
        .clk   (clk),
        .rst   (resetb),
        .din   (new_cntr_preset),
        .pulse (load_pulse)
    );

    assign dir     = decode_dir(enable_cnt_up, enable_cnt_dn);
    assign cnt_inc = cnt + ONE_CNT;
    assign cnt_dec = cnt - ONE_CNT;

    // Next count and expiry: the flag is OR-accumulated so only load or reset can clear it.
    always_comb begin
        cnt_nxt     = cnt;
        expired_nxt = ctr_expired;
        if (load_pulse) begin
            cnt_nxt     = new_cntr_preset_value;
            expired_nxt = 1'b0;
        end else if (pause_counting) begin
            cnt_nxt     = cnt;
            expired_nxt = ctr_expired;
        end else begin
            case (dir)
                DIR_UP: begin
                    if (cnt != MAX_CNT) begin
                        cnt_nxt     = cnt_inc;
                        expired_nxt = ctr_expired | (cnt_inc == MAX_CNT);
                    end else begin
                        cnt_nxt     = cnt;
                        expired_nxt = 1'b1;
                    end
                end
                DIR_DN: begin
                    if (cnt != ZERO_CNT) begin
                        cnt_nxt     = cnt_dec;
                        expired_nxt = ctr_expired | (cnt_dec == ZERO_CNT);
                    end else begin
                        cnt_nxt     = cnt;
                        expired_nxt = 1'b1;
                    end
                end
                default: begin
                    cnt_nxt     = cnt;
                    expired_nxt = ctr_expired;
                end
            endcase
        end
    end

    // Counter and flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (resetb) begin
            cnt         <= PRESET_CNT;
            ctr_expired <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            ctr_expired <= expired_nxt;
        end
    end

endmodule

// File: tb/tb_versatile_updown_counter.sv
// Directed bench for versatile_updown_counter: expected count/flag pairs are queued at drive
// time and popped after the following clock edge for comparison.
module tb_versatile_updown_counter;

    logic       clk;
    logic       resetb;
    logic       new_cntr_preset;
    logic [7:0] new_cntr_preset_value;
    logic       enable_cnt_up;
    logic       enable_cnt_dn;
    logic       pause_counting;
    logic       ctr_expired;

    logic [8:0] sb[$];
    int         n_vec;
    int         n_fail;

    versatile_updown_counter dut (
        .clk                   (clk),
        .resetb                (resetb),
        .new_cntr_preset       (new_cntr_preset),
        .new_cntr_preset_value (new_cntr_preset_value),
        .enable_cnt_up         (enable_cnt_up),
        .enable_cnt_dn         (enable_cnt_dn),
        .pause_counting        (pause_counting),
        .ctr_expired           (ctr_expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic rst, input logic pre, input logic [7:0] val,
                        input logic up, input logic dn, input logic pause,
                        input logic [7:0] exp_cnt, input logic exp_exp, input string tag);
        logic [8:0] exp_pair;
        logic [7:0] obs_cnt;
        @(negedge clk);
        resetb                = rst;
        new_cntr_preset       = pre;
        new_cntr_preset_value = val;
        enable_cnt_up         = up;
        enable_cnt_dn         = dn;
        pause_counting        = pause;
        sb.push_back({exp_cnt, exp_exp});
        @(posedge clk);
        #1;
        exp_pair = sb.pop_front();
        obs_cnt  = dut.cnt;
        n_vec++;
        assert (obs_cnt === exp_pair[8:1]) else begin
            n_fail++;
            $error("FAIL %s cnt: got %0d expected %0d", tag, obs_cnt, exp_pair[8:1]);
        end
        n_vec++;
        assert (ctr_expired === exp_pair[0]) else begin
            n_fail++;
            $error("FAIL %s ctr_expired: got %0b expected %0b", tag, ctr_expired, exp_pair[0]);
        end
    endtask

    initial begin
        n_vec                 = 0;
        n_fail                = 0;
        resetb                = 1'b1;
        new_cntr_preset       = 1'b0;
        new_cntr_preset_value = 8'd0;
        enable_cnt_up         = 1'b0;
        enable_cnt_dn         = 1'b0;
        pause_counting        = 1'b0;

        // reset held two cycles, then idle
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd200, 1'b0, "reset");
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd200, 1'b0, "reset");
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd200, 1'b0, "idle");

        // preset edge, then held high while counting up: no reload
        step(1'b0, 1'b1, 8'd10, 1'b0, 1'b0, 1'b0, 8'd10, 1'b0, "preset_load");
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 8'd10, 1'b1, 1'b0, 1'b0, 8'(11 + i), 1'b0, "count_up_held_preset");

        // pause freezes for exactly 15 edges, then resumes
        for (int i = 0; i < 15; i++)
            step(1'b0, 1'b1, 8'd10, 1'b1, 1'b0, 1'b1, 8'd13, 1'b0, "pause");
        step(1'b0, 1'b1, 8'd10, 1'b1, 1'b0, 1'b0, 8'd14, 1'b0, "resume");
        step(1'b0, 1'b1, 8'd10, 1'b1, 1'b0, 1'b0, 8'd15, 1'b0, "resume");
        step(1'b0, 1'b0, 8'd10, 1'b1, 1'b0, 1'b0, 8'd16, 1'b0, "preset_low");

        // load 3 (beats dn), count down to 0, saturate, then sticky while counting up
        step(1'b0, 1'b1, 8'd3, 1'b0, 1'b1, 1'b0, 8'd3, 1'b0, "load_beats_dn");
        step(1'b0, 1'b1, 8'd3, 1'b0, 1'b1, 1'b0, 8'd2, 1'b0, "count_dn");
        step(1'b0, 1'b1, 8'd3, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0, "count_dn");
        step(1'b0, 1'b1, 8'd3, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, "dn_terminal");
        step(1'b0, 1'b1, 8'd3, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, "dn_saturate");
        step(1'b0, 1'b1, 8'd3, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, "dn_saturate");
        step(1'b0, 1'b1, 8'd3, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1, "sticky_up");
        step(1'b0, 1'b1, 8'd3, 1'b1, 1'b0, 1'b0, 8'd2, 1'b1, "sticky_up");
        step(1'b0, 1'b1, 8'd3, 1'b1, 1'b0, 1'b1, 8'd2, 1'b1, "sticky_pause");
        step(1'b0, 1'b1, 8'd3, 1'b1, 1'b1, 1'b0, 8'd2, 1'b1, "both_enables");

        // up to 255 with saturation, then a re-edge clears the flag
        step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd2, 1'b1, "hold");
        step(1'b0, 1'b1, 8'd253, 1'b0, 1'b0, 1'b0, 8'd253, 1'b0, "load_253");
        step(1'b0, 1'b1, 8'd253, 1'b1, 1'b0, 1'b0, 8'd254, 1'b0, "count_up");
        step(1'b0, 1'b1, 8'd253, 1'b1, 1'b0, 1'b0, 8'd255, 1'b1, "up_terminal");
        step(1'b0, 1'b1, 8'd253, 1'b1, 1'b0, 1'b0, 8'd255, 1'b1, "up_saturate");
        step(1'b0, 1'b0, 8'd253, 1'b1, 1'b0, 1'b0, 8'd255, 1'b1, "up_saturate");
        step(1'b0, 1'b1, 8'd5, 1'b1, 1'b0, 1'b0, 8'd5, 1'b0, "reload_clears");
        step(1'b0, 1'b1, 8'd5, 1'b1, 1'b1, 1'b0, 8'd5, 1'b0, "both_enables");
        step(1'b0, 1'b1, 8'd5, 1'b1, 1'b1, 1'b0, 8'd5, 1'b0, "both_enables");
        step(1'b0, 1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 8'd5, 1'b0, "no_enables");

        // load coinciding with pause and up
        step(1'b0, 1'b0, 8'd5, 1'b0, 1'b0, 1'b0, 8'd5, 1'b0, "hold");
        step(1'b0, 1'b1, 8'd77, 1'b1, 1'b0, 1'b1, 8'd77, 1'b0, "load_beats_pause");
        step(1'b0, 1'b1, 8'd77, 1'b1, 1'b0, 1'b1, 8'd77, 1'b0, "pause_after_load");
        step(1'b0, 1'b1, 8'd77, 1'b1, 1'b0, 1'b0, 8'd78, 1'b0, "count_up");

        // reset while expired and counting
        step(1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 8'd78, 1'b0, "hold");
        step(1'b0, 1'b1, 8'd1, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0, "load_1");
        step(1'b0, 1'b1, 8'd1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, "dn_terminal");
        step(1'b1, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0, 8'd200, 1'b0, "reset_mid_count");
        step(1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0, 8'd201, 1'b0, "count_after_reset");
        step(1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b1, 8'd201, 1'b0, "pause");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
